// File: rtl/seven_seg_pkg.sv
// Shared segment encodings for the word scroller.
// Patterns are abcdefgh, active-high, a = bit 7.
package seven_seg_pkg;

  typedef logic [7:0] seg_pattern_t;

  typedef enum logic [7:0] {
    SEG_SPACE = 8'h00,
    SEG_F     = 8'h8E,
    SEG_P     = 8'hCE,
    SEG_G     = 8'hBC,
    SEG_A     = 8'hEE,
    SEG_V     = 8'h7C,
    SEG_K     = 8'h6E,
    SEG_0     = 8'hFC,
    SEG_1     = 8'h60,
    SEG_2     = 8'hDA,
    SEG_3     = 8'hF2,
    SEG_4     = 8'h66,
    SEG_5     = 8'hB6,
    SEG_6     = 8'hBE,
    SEG_7     = 8'hE0,
    SEG_8     = 8'hFE,
    SEG_9     = 8'hF6
  } seven_seg_encoding_e;

  function automatic int width_of(int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/seven_segment_word_scroller_if.sv
// Message in / display out bundle of the word scroller.
// master: lab logic; slave: scroller (msg, msg_load, run, dir in).
interface seven_segment_word_scroller_if
  import seven_seg_pkg::*;
#(
  parameter int w_digit   = 8,
  parameter int n_letters = 16
);

  logic [8*n_letters-1:0] msg;
  logic                   msg_load;
  logic                   run;
  logic                   dir;
  seg_pattern_t           abcdefgh;
  logic [w_digit-1:0]     digit;
  logic                   wrap;

  modport master (
    output msg, msg_load, run, dir,
    input  abcdefgh, digit, wrap
  );

  modport slave (
    input  msg, msg_load, run, dir,
    output abcdefgh, digit, wrap
  );

endinterface

// File: rtl/strobe_gen.sv
// Free-running counter emitting a one-cycle pulse every period cycles.
// Ports: clk, rst (sync, active-high), pulse.
module strobe_gen #(
  parameter int period = 1
) (
  input  logic clk,
  input  logic rst,
  output logic pulse
);

  localparam int CW = (period > 1) ? $clog2(period) : 1;
  localparam logic [CW-1:0] LAST = CW'(period - 1);

  if (period < 1) begin : g_bad_period
    $error("strobe_gen: period must be at least 1");
  end

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign pulse = (cnt == LAST);

endmodule

// File: rtl/seven_segment_word_scroller.sv
// Multiplexed 8-segment message display with left/right scrolling.
// Ports: clk, rst (sync, active-high), bus (slave modport).
module seven_segment_word_scroller
  import seven_seg_pkg::*;
#(
  parameter int clk_mhz   = 50,
  parameter int w_digit   = 8,
  parameter int n_letters = 16,
  parameter int scan_hz   = 1000,
  parameter int step_ms   = 250
) (
  input logic clk,
  input logic rst,
  seven_segment_word_scroller_if.slave bus
);

  localparam int SCAN_P = clk_mhz * 1_000_000 / scan_hz;
  localparam int STEP_P = clk_mhz * 1000 * step_ms;
  localparam int OW = width_of(n_letters);
  localparam int IW = width_of(w_digit);
  localparam int SW = $clog2(n_letters + w_digit) + 1;
  localparam int NSUB = w_digit / n_letters + 1;

  localparam logic [OW-1:0] OFF_LAST = OW'(n_letters - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(w_digit - 1);
  localparam logic [SW-1:0] N_SW = SW'(n_letters);
  localparam logic [w_digit-1:0] ONE = w_digit'(1);

  if (SCAN_P < 1) begin : g_bad_scan
    $error("scroller: scan period below one cycle");
  end
  if (n_letters < 1) begin : g_bad_len
    $error("scroller: n_letters must be at least 1");
  end

  logic [8*n_letters-1:0] msg_q;
  logic [OW-1:0]          offset;
  logic [OW-1:0]          offset_nx;
  logic [IW-1:0]          idx;
  logic                   wrap_nx;
  logic                   scan_stb;
  logic                   step_stb;
  logic [SW-1:0]          lsum;

  strobe_gen #(.period(SCAN_P)) u_scan (
    .clk   (clk),
    .rst   (rst),
    .pulse (scan_stb)
  );

  strobe_gen #(.period(STEP_P)) u_step (
    .clk   (clk),
    .rst   (rst),
    .pulse (step_stb)
  );

  // A load overrides a coincident step and never flags a wrap.
  always_comb begin
    offset_nx = offset;
    wrap_nx   = 1'b0;
    if (step_stb && bus.run) begin
      if (!bus.dir) begin
        offset_nx = (offset == OFF_LAST) ? '0 : offset + OW'(1);
      end else begin
        offset_nx = (offset == '0) ? OFF_LAST : offset - OW'(1);
      end
      wrap_nx = (offset_nx == '0);
    end
    if (bus.msg_load) begin
      offset_nx = '0;
      wrap_nx   = 1'b0;
    end
  end

  // Letter index for the scanned digit; repeated subtraction
  // also covers messages shorter than the display.
  always_comb begin
    lsum = SW'(offset) + SW'(IDX_LAST - idx);
    for (int k = 0; k < NSUB; k++) begin
      if (lsum >= N_SW) lsum = lsum - N_SW;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      msg_q        <= '0;
      offset       <= '0;
      idx          <= '0;
      bus.abcdefgh <= '0;
      bus.digit    <= '0;
      bus.wrap     <= 1'b0;
    end else begin
      if (bus.msg_load) msg_q <= bus.msg;
      offset   <= offset_nx;
      bus.wrap <= wrap_nx;
      if (scan_stb) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end
      bus.abcdefgh <= msg_q[8*lsum +: 8];
      bus.digit    <= ONE << idx;
    end
  end

endmodule

// File: tb/tb_seven_segment_word_scroller.sv
// Self-checking bench: directed scenarios plus random traffic
// compared cycle by cycle against an arithmetic model.
module tb_seven_segment_word_scroller;
  import seven_seg_pkg::*;

  localparam int W = 4;
  localparam int N = 6;
  localparam int SCAN = 4;
  localparam int STEP = 1000;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seven_segment_word_scroller_if #(.w_digit(W), .n_letters(N)) bus ();

  seven_segment_word_scroller #(
    .clk_mhz   (1),
    .w_digit   (W),
    .n_letters (N),
    .scan_hz   (250000),
    .step_ms   (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Model: k = edges since last reset edge; scan/step strobes
  // fall on multiples of their periods.
  int           k;
  seg_pattern_t m_msg [N];
  int           m_off;
  logic [W-1:0] e_dig;
  seg_pattern_t e_seg;
  logic         e_wrap;

  task automatic tick();
    logic r, ld, rn, dr;
    logic [8*N-1:0] mv;
    int ip;
    r  = rst;
    ld = bus.msg_load;
    rn = bus.run;
    dr = bus.dir;
    mv = bus.msg;
    @(posedge clk);
    if (r) begin
      k = 0;
      m_off = 0;
      for (int i = 0; i < N; i++) m_msg[i] = 8'h00;
      e_dig = '0;
      e_seg = 8'h00;
      e_wrap = 1'b0;
    end else begin
      k++;
      ip = ((k - 1) / SCAN) % W;
      e_dig = W'(1 << ip);
      e_seg = m_msg[(m_off + W - 1 - ip) % N];
      e_wrap = 1'b0;
      if (ld) begin
        m_off = 0;
        for (int i = 0; i < N; i++) m_msg[i] = mv[8*i +: 8];
      end else if ((k % STEP == 0) && rn) begin
        m_off = dr ? (m_off + N - 1) % N : (m_off + 1) % N;
        e_wrap = (m_off == 0);
      end
    end
    #1;
    check("digit", 32'(bus.digit), 32'(e_dig));
    check("seg", 32'(bus.abcdefgh), 32'(e_seg));
    check("wrap", 32'(bus.wrap), 32'(e_wrap));
  endtask

  task automatic run_to(int target);
    while (k < target) tick();
  endtask

  // Advance until the sampled output is the leftmost digit.
  task automatic to_left();
    int g;
    g = 0;
    do begin
      tick();
      g++;
    end while ((((k - 1) / SCAN) % W) != W - 1 && g < 4 * SCAN * W);
  endtask

  seg_pattern_t pool [17];
  logic [11:0]  static_tab [W];

  function automatic logic [8*N-1:0] rand_msg();
    logic [8*N-1:0] v;
    for (int i = 0; i < N; i++) v[8*i +: 8] = pool[$urandom_range(0, 16)];
    return v;
  endfunction

  initial begin
    pool = '{SEG_SPACE, SEG_F, SEG_P, SEG_G, SEG_A, SEG_V, SEG_K,
             SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6,
             SEG_7, SEG_8, SEG_9};
    static_tab = '{12'h1EE, 12'h2BC, 12'h4CE, 12'h88E};
    k = 0;
    m_off = 0;

    rst = 1'b1;
    bus.msg = '0;
    bus.msg_load = 1'b0;
    bus.run = 1'b0;
    bus.dir = 1'b0;
    repeat (3) tick();
    check("rst_seg", 32'(bus.abcdefgh), 32'h0);
    check("rst_digit", 32'(bus.digit), 32'h0);
    check("rst_wrap", 32'(bus.wrap), 32'h0);

    rst = 1'b0;
    tick();
    check("rel_digit", 32'(bus.digit), 32'h1);

    bus.msg = {SEG_K, SEG_V, SEG_A, SEG_G, SEG_P, SEG_F};
    bus.msg_load = 1'b1;
    tick();
    bus.msg_load = 1'b0;
    repeat (4 * SCAN) begin
      tick();
      check("static", 32'({bus.digit, bus.abcdefgh}),
            32'(static_tab[((k - 1) / SCAN) % W]));
    end

    bus.run = 1'b1;
    bus.dir = 1'b0;
    run_to(STEP);
    check("left1_wrap", 32'(bus.wrap), 32'h0);
    to_left();
    check("left1", 32'({bus.digit, bus.abcdefgh}), 32'h8CE);
    run_to(6 * STEP);
    check("left6_wrap", 32'(bus.wrap), 32'h1);
    tick();
    check("wrap_pulse", 32'(bus.wrap), 32'h0);
    to_left();
    check("left6", 32'({bus.digit, bus.abcdefgh}), 32'h88E);

    bus.dir = 1'b1;
    run_to(7 * STEP);
    check("right1_wrap", 32'(bus.wrap), 32'h0);
    to_left();
    check("right1", 32'({bus.digit, bus.abcdefgh}), 32'h86E);
    run_to(12 * STEP);
    check("right6_wrap", 32'(bus.wrap), 32'h1);

    bus.dir = 1'b0;
    run_to(16 * STEP - 1);
    bus.msg = rand_msg();
    bus.msg_load = 1'b1;
    tick();
    bus.msg_load = 1'b0;
    check("collide_wrap", 32'(bus.wrap), 32'h0);
    repeat (2 * SCAN * W) tick();

    run_to(20 * STEP + 5);
    rst = 1'b1;
    tick();
    check("mid_rst_seg", 32'(bus.abcdefgh), 32'h0);
    check("mid_rst_digit", 32'(bus.digit), 32'h0);
    rst = 1'b0;
    repeat (SCAN * W) begin
      tick();
      check("blank", 32'(bus.abcdefgh), 32'h0);
    end

    repeat (20000) begin
      bus.run = ($urandom_range(0, 3) != 0);
      bus.dir = $urandom_range(0, 1) == 1;
      bus.msg_load = ($urandom_range(0, 299) == 0) ||
                     ((k % STEP == STEP - 1) && $urandom_range(0, 3) == 0);
      if (bus.msg_load) bus.msg = rand_msg();
      rst = ($urandom_range(0, 6999) == 0);
      tick();
    end
    rst = 1'b0;
    bus.msg_load = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
